// File: rtl/m_pte_responder_pkg.sv
// Shared types and defaults for the page-walk PTE responder.
// The state encoding and default timeout are shared with the MMU-side code.
package m_pte_responder_pkg;

  typedef enum logic [1:0] {
    PTE_RSP_IDLE  = 2'd0,
    PTE_RSP_ISSUE = 2'd1,
    PTE_RSP_WAIT  = 2'd2,
    PTE_RSP_ERR   = 2'd3
  } pte_rsp_state_e;

  localparam int PTE_RSP_TIMEOUT = 1023;

  function automatic logic pte_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/m_pte_responder.sv
// Sequences walker PTE reads and A/D write-backs onto the single DRAM port.
// Busy/rdata timing matches a walker that samples data on the first busy-low cycle.
module m_pte_responder
  import m_pte_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = PTE_RSP_TIMEOUT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  w_pte_req,
  input  logic                  w_pte_we,
  input  logic [ADDR_WIDTH-1:0] w_pte_addr,
  input  logic [31:0]           w_pte_wdata,
  output logic                  w_pte_busy,
  output logic [31:0]           w_pte_rdata,
  output logic                  w_pte_err,
  output logic [ADDR_WIDTH-1:0] w_dram_addr,
  output logic [31:0]           w_dram_wdata,
  output logic                  w_dram_le,
  output logic                  w_dram_we,
  input  logic                  w_dram_busy,
  input  logic [31:0]           w_dram_odata,
  output logic [31:0]           w_pte_rd_cnt,
  output logic [31:0]           w_pte_wr_cnt
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  pte_rsp_state_e        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  we_lat_q, we_lat_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           rd_cnt_q, rd_cnt_d;
  logic [31:0]           wr_cnt_q, wr_cnt_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;
  logic                  le_q, le_d;
  logic                  st_q, st_d;

  // Outputs are registered: each is set from the state being entered, not the current one.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_lat_d = we_lat_q;
    rdata_d  = rdata_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    busy_d   = busy_q;
    err_d    = 1'b0;
    le_d     = 1'b0;
    st_d     = 1'b0;
    case (state_q)
      PTE_RSP_IDLE: begin
        if (w_pte_req) begin
          addr_d   = w_pte_addr;
          wdata_d  = w_pte_wdata;
          we_lat_d = w_pte_we;
          busy_d   = 1'b1;
          if (!pte_word_aligned(w_pte_addr[1:0])) begin
            state_d = PTE_RSP_ERR;
            err_d   = 1'b1;
            rdata_d = 32'h0000_0000;
          end else begin
            state_d = PTE_RSP_ISSUE;
            le_d    = ~w_pte_we;
            st_d    = w_pte_we;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      PTE_RSP_ISSUE: begin
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = PTE_RSP_WAIT;
      end
      PTE_RSP_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // cnt_q == 0 marks the first WAIT cycle, where DRAM busy may not have risen yet.
        if ((cnt_q != '0) && !w_dram_busy) begin
          state_d = PTE_RSP_IDLE;
          busy_d  = 1'b0;
          if (we_lat_q) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
          end else begin
            rdata_d  = w_dram_odata;
            rd_cnt_d = rd_cnt_q + 32'd1;
          end
        end else if (cnt_d == CNT_W'(TIMEOUT)) begin
          state_d = PTE_RSP_ERR;
          err_d   = 1'b1;
          rdata_d = 32'h0000_0000;
        end else begin
          state_d = PTE_RSP_WAIT;
        end
      end
      PTE_RSP_ERR: begin
        busy_d  = 1'b0;
        state_d = PTE_RSP_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = PTE_RSP_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= PTE_RSP_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= 32'h0000_0000;
      we_lat_q <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      rd_cnt_q <= 32'h0000_0000;
      wr_cnt_q <= 32'h0000_0000;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      le_q     <= 1'b0;
      st_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_lat_q <= we_lat_d;
      rdata_q  <= rdata_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      le_q     <= le_d;
      st_q     <= st_d;
    end
  end

  assign w_pte_busy   = busy_q;
  assign w_pte_rdata  = rdata_q;
  assign w_pte_err    = err_q;
  assign w_dram_addr  = addr_q;
  assign w_dram_wdata = wdata_q;
  assign w_dram_le    = le_q;
  assign w_dram_we    = st_q;
  assign w_pte_rd_cnt = rd_cnt_q;
  assign w_pte_wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_m_pte_responder.sv
// Directed bench for m_pte_responder: vector table of back-to-back accesses plus
// hand-written ignored-request and reset-during-WAIT sequences.
module tb_m_pte_responder;

  localparam int TO = 8;

  logic        CLK;
  logic        RST;
  logic        w_pte_req;
  logic        w_pte_we;
  logic [31:0] w_pte_addr;
  logic [31:0] w_pte_wdata;
  logic        w_pte_busy;
  logic [31:0] w_pte_rdata;
  logic        w_pte_err;
  logic [31:0] w_dram_addr;
  logic [31:0] w_dram_wdata;
  logic        w_dram_le;
  logic        w_dram_we;
  logic        w_dram_busy;
  logic [31:0] w_dram_odata;
  logic [31:0] w_pte_rd_cnt;
  logic [31:0] w_pte_wr_cnt;

  logic        dram_hold;
  int          dram_k;
  int          rem;
  int          tests;
  int          fails;

  typedef struct {
    logic        we;
    logic        hold;
    int          k;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] odata;
    int          exp_lat;
    int          exp_err_cyc;
    int          exp_le;
    int          exp_we;
    logic [31:0] exp_rdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_wr;
  } vec_t;

  vec_t vecs[8];

  m_pte_responder #(.ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .w_pte_req    (w_pte_req),
    .w_pte_we     (w_pte_we),
    .w_pte_addr   (w_pte_addr),
    .w_pte_wdata  (w_pte_wdata),
    .w_pte_busy   (w_pte_busy),
    .w_pte_rdata  (w_pte_rdata),
    .w_pte_err    (w_pte_err),
    .w_dram_addr  (w_dram_addr),
    .w_dram_wdata (w_dram_wdata),
    .w_dram_le    (w_dram_le),
    .w_dram_we    (w_dram_we),
    .w_dram_busy  (w_dram_busy),
    .w_dram_odata (w_dram_odata),
    .w_pte_rd_cnt (w_pte_rd_cnt),
    .w_pte_wr_cnt (w_pte_wr_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DRAM model: busy for dram_k cycles starting the cycle after a strobe.
  always @(posedge CLK) begin
    if (RST) rem <= 0;
    else if (w_dram_le || w_dram_we) rem <= dram_k;
    else if (rem > 0) rem <= rem - 1;
  end
  assign w_dram_busy = dram_hold || (rem > 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; issues one request and returns at the negedge where busy is low.
  task automatic run_access(input vec_t v, input int pulse_at);
    int cyc, err_cyc, le_cnt, we_cnt, stb_cyc;
    w_pte_req    = 1'b1;
    w_pte_we     = v.we;
    w_pte_addr   = v.addr;
    w_pte_wdata  = v.wdata;
    w_dram_odata = v.odata;
    dram_k       = v.k;
    dram_hold    = v.hold;
    @(negedge CLK);
    w_pte_req = 1'b0;
    cyc = 1; err_cyc = 0; le_cnt = 0; we_cnt = 0; stb_cyc = 0;
    while (w_pte_busy && cyc < 64) begin
      if (w_pte_err) err_cyc = cyc;
      if (w_dram_le) le_cnt++;
      if (w_dram_we) we_cnt++;
      if (w_dram_le || w_dram_we) begin
        stb_cyc = cyc;
        chk("strobe_addr", w_dram_addr, v.addr);
        if (w_dram_we) chk("strobe_wdata", w_dram_wdata, v.wdata);
      end
      if (cyc == pulse_at) begin
        w_pte_req  = 1'b1;
        w_pte_we   = 1'b1;
        w_pte_addr = 32'h8000_0500;
      end else begin
        w_pte_req = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    w_pte_req = 1'b0;
    dram_hold = 1'b0;
    chk("latency", 32'(cyc), 32'(v.exp_lat));
    chk("err_cycle", 32'(err_cyc), 32'(v.exp_err_cyc));
    chk("le_count", 32'(le_cnt), 32'(v.exp_le));
    chk("we_count", 32'(we_cnt), 32'(v.exp_we));
    chk("strobe_cycle", 32'(stb_cyc), ((v.exp_le + v.exp_we) > 0) ? 32'd1 : 32'd0);
    chk("rdata", w_pte_rdata, v.exp_rdata);
    chk("rd_cnt", w_pte_rd_cnt, v.exp_rd);
    chk("wr_cnt", w_pte_wr_cnt, v.exp_wr);
    chk("err_low", 32'(w_pte_err), 32'd0);
  endtask

  initial begin
    vec_t v;
    tests = 0; fails = 0;
    RST = 1'b1; w_pte_req = 1'b0; w_pte_we = 1'b0; w_pte_addr = 32'h0;
    w_pte_wdata = 32'h0; w_dram_odata = 32'h0; dram_hold = 1'b0; dram_k = 0;

    //           we    hold  k  addr          wdata         odata         lat err le we rdata         rd     wr
    vecs[0] = '{1'b0, 1'b0, 3, 32'h8000_1004, 32'h0,        32'h2000_04CF, 6, 0, 1, 0, 32'h2000_04CF, 32'd1, 32'd0};
    vecs[1] = '{1'b1, 1'b0, 2, 32'h8000_2008, 32'h0000_00C7, 32'hDEAD_BEEF, 5, 0, 0, 1, 32'h2000_04CF, 32'd1, 32'd1};
    vecs[2] = '{1'b0, 1'b0, 3, 32'h8000_1002, 32'h0,        32'h1111_1111, 2, 1, 0, 0, 32'h0000_0000, 32'd1, 32'd1};
    vecs[3] = '{1'b0, 1'b0, 1, 32'h8000_0010, 32'h0,        32'h1234_5678, 4, 0, 1, 0, 32'h1234_5678, 32'd2, 32'd1};
    vecs[4] = '{1'b1, 1'b0, 1, 32'h8000_0003, 32'h0000_00FF, 32'h2222_2222, 2, 1, 0, 0, 32'h0000_0000, 32'd2, 32'd1};
    vecs[5] = '{1'b0, 1'b0, 1, 32'h0000_0000, 32'h0,        32'hA5A5_0001, 4, 0, 1, 0, 32'hA5A5_0001, 32'd3, 32'd1};
    vecs[6] = '{1'b0, 1'b1, 0, 32'h8000_0100, 32'h0,        32'h3333_3333, 11, 10, 1, 0, 32'h0000_0000, 32'd3, 32'd1};
    vecs[7] = '{1'b0, 1'b0, 7, 32'h8000_0104, 32'h0,        32'h0000_0C01, 10, 0, 1, 0, 32'h0000_0C01, 32'd4, 32'd1};

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("rst_busy", 32'(w_pte_busy), 32'd0);
    chk("rst_err", 32'(w_pte_err), 32'd0);
    chk("rst_rdata", w_pte_rdata, 32'h0);
    chk("rst_rd_cnt", w_pte_rd_cnt, 32'h0);
    chk("rst_wr_cnt", w_pte_wr_cnt, 32'h0);
    chk("rst_strobes", 32'({w_dram_le, w_dram_we}), 32'd0);

    // Back-to-back: each vector is requested in the cycle the previous busy falls.
    for (int i = 0; i < 8; i++) run_access(vecs[i], 0);

    // Write request pulsed during WAIT must be ignored.
    v = '{1'b0, 1'b0, 4, 32'h8000_0200, 32'h0, 32'h0BAD_F00D, 7, 0, 1, 0, 32'h0BAD_F00D, 32'd5, 32'd1};
    run_access(v, 3);
    @(negedge CLK);
    chk("ignored_no_busy", 32'(w_pte_busy), 32'd0);
    chk("ignored_no_strobe", 32'({w_dram_le, w_dram_we}), 32'd0);

    // Reset in the middle of WAIT abandons the access.
    w_pte_req = 1'b1; w_pte_we = 1'b0; w_pte_addr = 32'h8000_0040;
    w_dram_odata = 32'h4444_4444; dram_k = 5;
    @(negedge CLK);
    w_pte_req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("pre_rst_busy", 32'(w_pte_busy), 32'd1);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("wrst_busy", 32'(w_pte_busy), 32'd0);
    chk("wrst_rd_cnt", w_pte_rd_cnt, 32'h0);
    chk("wrst_wr_cnt", w_pte_wr_cnt, 32'h0);
    chk("wrst_rdata", w_pte_rdata, 32'h0);
    chk("wrst_strobe0", 32'({w_dram_le, w_dram_we}), 32'd0);
    @(negedge CLK);
    chk("wrst_strobe1", 32'({w_dram_le, w_dram_we}), 32'd0);
    chk("wrst_busy1", 32'(w_pte_busy), 32'd0);

    v = '{1'b0, 1'b0, 2, 32'h8000_0300, 32'h0, 32'h3000_0001, 5, 0, 1, 0, 32'h3000_0001, 32'd1, 32'd0};
    run_access(v, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
